// File: rtl/cnn_mem_pkg.sv
// Shared types and constants for the OBI feature-map memory slice.
// The OBI request/response structs are fixed at 32-bit address/data and 4-bit ids.
package cnn_mem_pkg;

    localparam int unsigned ObiAddrWidth = 32;
    localparam int unsigned ObiDataWidth = 32;
    localparam int unsigned ObiIdWidth   = 4;

    localparam logic [31:0] ErrRdata   = 32'hDEAD_BEEF;
    localparam int unsigned MaxLatency = 4;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{
        AddrWidth: ObiAddrWidth,
        DataWidth: ObiDataWidth,
        IdWidth:   ObiIdWidth
    };

    typedef struct packed {
        logic [ObiAddrWidth-1:0] addr;
        logic                    we;
        logic [3:0]              be;
        logic [ObiDataWidth-1:0] wdata;
        logic [ObiIdWidth-1:0]   aid;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic [ObiDataWidth-1:0] rdata;
        logic [ObiIdWidth-1:0]   rid;
        logic                    err;
        logic                    r_optional;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

    // One slot of the response delay line; the whole slot is zero when idle.
    typedef struct packed {
        logic                    valid;
        logic [ObiIdWidth-1:0]   id;
        logic                    err;
        logic [ObiDataWidth-1:0] rdata;
    } rsp_stage_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/obi_rsp_pipe.sv
// Fixed-depth delay line carrying response slots from accept to rvalid.
// Every accept advances one slot per cycle, so back-to-back accepts leave no bubbles.
module obi_rsp_pipe
    import cnn_mem_pkg::*;
#(
    parameter int unsigned Latency = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  rsp_stage_t i_stage,
    output rsp_stage_t o_stage
);

    rsp_stage_t r_stages [Latency];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Latency; i++) begin
                r_stages[i] <= '0;
            end
        end else begin
            r_stages[0] <= i_stage;
            for (int i = 1; i < Latency; i++) begin
                r_stages[i] <= r_stages[i-1];
            end
        end
    end

    assign o_stage = r_stages[Latency-1];

endmodule

// File: rtl/obi_fmap_mem.sv
// Single-port OBI subordinate word memory with fixed response latency and
// saturating access counters; always grants, flags out-of-range/misaligned accesses.
module obi_fmap_mem
    import cnn_mem_pkg::*;
#(
    parameter obi_cfg_t    ObiCfg   = ObiDefaultConfig,
    parameter int unsigned NumWords = 256,
    parameter logic [31:0] BaseAddr = 32'h1A10_0000,
    parameter int unsigned Latency  = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        testmode_i,
    input  obi_req_t    obi_req_i,
    output obi_rsp_t    obi_rsp_o,
    output logic [15:0] rd_count_o,
    output logic [15:0] wr_count_o,
    output logic [15:0] err_count_o
);

    localparam int unsigned IdxWidth  = $clog2(NumWords);
    localparam logic [32:0] SpanBytes = 33'(NumWords) << 2;

    if (Latency < 1 || Latency > MaxLatency) begin : g_bad_latency
        $fatal(1, "obi_fmap_mem: Latency %0d outside 1..%0d", Latency, MaxLatency);
    end
    if (!is_pow2(NumWords) || NumWords < 16 || NumWords > 1024) begin : g_bad_depth
        $fatal(1, "obi_fmap_mem: NumWords %0d must be a power of two in 16..1024", NumWords);
    end
    if (ObiCfg.AddrWidth != ObiAddrWidth || ObiCfg.DataWidth != ObiDataWidth ||
        ObiCfg.IdWidth != ObiIdWidth) begin : g_bad_cfg
        $fatal(1, "obi_fmap_mem: ObiCfg does not match the package OBI struct widths");
    end

    logic [31:0]         r_mem [NumWords];
    logic [15:0]         r_rd_count;
    logic [15:0]         r_wr_count;
    logic [15:0]         r_err_count;

    logic [32:0]         w_offset;
    logic                w_in_range;
    logic [IdxWidth-1:0] w_idx;
    logic                w_wr_ok;
    rsp_stage_t          w_stage_in;
    rsp_stage_t          w_stage_out;
    logic                w_unused;

    // A 33-bit offset turns addresses below BaseAddr into huge values, so one compare covers both bounds.
    assign w_offset   = {1'b0, obi_req_i.a.addr} - {1'b0, BaseAddr};
    assign w_in_range = (w_offset < SpanBytes) && (obi_req_i.a.addr[1:0] == 2'b00);
    assign w_idx      = w_offset[IdxWidth+1:2];
    assign w_wr_ok    = obi_req_i.req && obi_req_i.a.we && w_in_range;
    assign w_unused   = testmode_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumWords; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (obi_req_i.a.be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= obi_req_i.a.wdata[8*b +: 8];
                end
            end
        end
    end

    // Read data is sampled combinationally here, so it sees memory before this edge's write.
    always_comb begin
        w_stage_in = '0;
        if (obi_req_i.req) begin
            w_stage_in.valid = 1'b1;
            w_stage_in.id    = obi_req_i.a.aid;
            if (!w_in_range) begin
                w_stage_in.err   = 1'b1;
                w_stage_in.rdata = ErrRdata;
            end else if (!obi_req_i.a.we) begin
                w_stage_in.rdata = r_mem[w_idx];
            end
        end
    end

    obi_rsp_pipe #(
        .Latency (Latency)
    ) u_rsp_pipe (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_stage (w_stage_in),
        .o_stage (w_stage_out)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_count  <= '0;
            r_wr_count  <= '0;
            r_err_count <= '0;
        end else if (obi_req_i.req) begin
            if (!w_in_range) begin
                r_err_count <= sat_inc(r_err_count);
            end else if (obi_req_i.a.we) begin
                r_wr_count <= sat_inc(r_wr_count);
            end else begin
                r_rd_count <= sat_inc(r_rd_count);
            end
        end
    end

    assign obi_rsp_o.gnt          = obi_req_i.req;
    assign obi_rsp_o.rvalid       = w_stage_out.valid;
    assign obi_rsp_o.r.rdata      = w_stage_out.rdata;
    assign obi_rsp_o.r.rid        = w_stage_out.id;
    assign obi_rsp_o.r.err        = w_stage_out.err;
    assign obi_rsp_o.r.r_optional = 1'b0;

    assign rd_count_o  = r_rd_count;
    assign wr_count_o  = r_wr_count;
    assign err_count_o = r_err_count;

endmodule

// File: tb/tb_obi_fmap_mem.sv
// Bench for obi_fmap_mem: a Latency=1 instance driven from a vector table and a
// Latency=3 instance for burst ordering and mid-flight reset, both scoreboarded.
module tb_obi_fmap_mem;
    import cnn_mem_pkg::*;

    localparam logic [31:0] Base = 32'h1A10_0000;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [3:0]  aid;
        logic        expErr;
        logic [31:0] expRdata;
    } vec_t;

    typedef struct {
        logic [3:0]  id;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstN1, rstN3, testmode;
    obi_req_t    req1, req3;
    obi_rsp_t    rsp1, rsp3;
    logic [15:0] rd1, wr1, er1, rd3, wr3, er3;

    int   cyc = 0;
    int   nChecks = 0;
    int   nPass = 0;
    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;
    vec_t tbl[15];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    obi_fmap_mem #(.Latency(1)) dut1 (
        .clk_i       (clk),
        .rst_ni      (rstN1),
        .testmode_i  (testmode),
        .obi_req_i   (req1),
        .obi_rsp_o   (rsp1),
        .rd_count_o  (rd1),
        .wr_count_o  (wr1),
        .err_count_o (er1)
    );

    obi_fmap_mem #(.Latency(3)) dut3 (
        .clk_i       (clk),
        .rst_ni      (rstN3),
        .testmode_i  (testmode),
        .obi_req_i   (req3),
        .obi_rsp_o   (rsp3),
        .rd_count_o  (rd3),
        .wr_count_o  (wr3),
        .err_count_o (er3)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Drives one request for a cycle; with pushExp set, the expected response is queued.
    task automatic applyStimulus(input int dut, input vec_t v, input bit pushExp);
        obi_req_t r;
        r.req     = 1'b1;
        r.a.addr  = v.addr;
        r.a.we    = v.we;
        r.a.be    = v.be;
        r.a.wdata = v.wdata;
        r.a.aid   = v.aid;
        if (dut == 1) begin
            req1 = r;
            if (pushExp) q1.push_back('{id: v.aid, err: v.expErr, rdata: v.expRdata, cyc: cyc + 1});
            #1 checkOutput("dut1 gnt", 32'(rsp1.gnt), 32'd1);
        end else begin
            req3 = r;
            if (pushExp) q3.push_back('{id: v.aid, err: v.expErr, rdata: v.expRdata, cyc: cyc + 3});
            #1 checkOutput("dut3 gnt", 32'(rsp3.gnt), 32'd1);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        req1 = '0;
        req3 = '0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((q1.size() != 0 || q3.size() != 0) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (q1.size() != 0 || q3.size() != 0) begin
            nChecks++;
            $display("[TB] FAIL drain timeout: got %0d/%0d responses pending, expected 0", q1.size(), q3.size());
            q1.delete();
            q3.delete();
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wdata, input logic [3:0] aid,
                                input logic expErr, input logic [31:0] expRdata);
        return '{we: we, addr: addr, be: be, wdata: wdata, aid: aid, expErr: expErr, expRdata: expRdata};
    endfunction

    always @(negedge clk) begin
        if (rsp1.rvalid) begin
            if (q1.size() == 0) begin
                nChecks++;
                $display("[TB] FAIL dut1 unexpected rvalid: got rid %0d, expected no response", rsp1.r.rid);
            end else begin
                e1 = q1.pop_front();
                checkOutput("dut1 rid", 32'(rsp1.r.rid), 32'(e1.id));
                checkOutput("dut1 err", 32'(rsp1.r.err), 32'(e1.err));
                checkOutput("dut1 rdata", rsp1.r.rdata, e1.rdata);
                checkOutput("dut1 rvalid cycle", 32'(cyc), 32'(e1.cyc));
                checkOutput("dut1 r_optional", 32'(rsp1.r.r_optional), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (rsp3.rvalid) begin
            if (q3.size() == 0) begin
                nChecks++;
                $display("[TB] FAIL dut3 unexpected rvalid: got rid %0d, expected no response", rsp3.r.rid);
            end else begin
                e3 = q3.pop_front();
                checkOutput("dut3 rid", 32'(rsp3.r.rid), 32'(e3.id));
                checkOutput("dut3 err", 32'(rsp3.r.err), 32'(e3.err));
                checkOutput("dut3 rdata", rsp3.r.rdata, e3.rdata);
                checkOutput("dut3 rvalid cycle", 32'(cyc), 32'(e3.cyc));
            end
        end
    end

    initial begin
        // Expected values are worked out by hand from the vector order.
        tbl[0]  = mk(1'b1, Base + 32'h8,   4'hF,    32'h1122_3344, 4'd1,  1'b0, 32'h0);
        tbl[1]  = mk(1'b0, Base + 32'h8,   4'hF,    32'h0,         4'd2,  1'b0, 32'h1122_3344);
        tbl[2]  = mk(1'b1, Base + 32'hC,   4'b0101, 32'hAABB_CCDD, 4'd3,  1'b0, 32'h0);
        tbl[3]  = mk(1'b0, Base + 32'hC,   4'hF,    32'h0,         4'd4,  1'b0, 32'h00BB_00DD);
        tbl[4]  = mk(1'b0, Base + 32'h400, 4'hF,    32'h0,         4'd5,  1'b1, 32'hDEAD_BEEF);
        tbl[5]  = mk(1'b0, Base + 32'h2,   4'hF,    32'h0,         4'd6,  1'b1, 32'hDEAD_BEEF);
        tbl[6]  = mk(1'b0, Base + 32'h3FC, 4'hF,    32'h0,         4'd7,  1'b0, 32'h0);
        tbl[7]  = mk(1'b1, Base + 32'h14,  4'hF,    32'hCAFE_F00D, 4'd8,  1'b0, 32'h0);
        tbl[8]  = mk(1'b0, Base + 32'h14,  4'hF,    32'h0,         4'd9,  1'b0, 32'hCAFE_F00D);
        tbl[9]  = mk(1'b0, Base + 32'h14,  4'hF,    32'h0,         4'd10, 1'b0, 32'hCAFE_F00D);
        tbl[10] = mk(1'b1, Base + 32'h14,  4'hF,    32'h0BAD_C0DE, 4'd11, 1'b0, 32'h0);
        tbl[11] = mk(1'b0, Base + 32'h14,  4'hF,    32'h0,         4'd12, 1'b0, 32'h0BAD_C0DE);
        tbl[12] = mk(1'b1, Base + 32'h8,   4'b1000, 32'hFF00_0000, 4'd13, 1'b0, 32'h0);
        tbl[13] = mk(1'b0, Base + 32'h8,   4'hF,    32'h0,         4'd14, 1'b0, 32'hFF22_3344);
        tbl[14] = mk(1'b0, Base + 32'h0,   4'hF,    32'h0,         4'd15, 1'b0, 32'h0);

        rstN1    = 1'b0;
        rstN3    = 1'b0;
        testmode = 1'b0;
        idle();

        // A write presented during reset must be granted yet leave memory untouched.
        req1.req     = 1'b1;
        req1.a.addr  = Base;
        req1.a.we    = 1'b1;
        req1.a.be    = 4'hF;
        req1.a.wdata = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset gnt tracks req", 32'(rsp1.gnt), 32'd1);
        checkOutput("reset rvalid", 32'(rsp1.rvalid), 32'd0);
        checkOutput("reset rdata", rsp1.r.rdata, 32'd0);
        checkOutput("reset rid/err", {27'd0, rsp1.r.rid, rsp1.r.err}, 32'd0);
        checkOutput("reset counters", {rd1, wr1 | er1}, 32'd0);
        idle();
        #1 checkOutput("gnt low with no req", 32'(rsp1.gnt), 32'd0);
        rstN1 = 1'b1;
        rstN3 = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) applyStimulus(1, tbl[i], 1'b1);
        idle();
        waitDrain();
        checkOutput("dut1 rd_count", 32'(rd1), 32'd8);
        checkOutput("dut1 wr_count", 32'(wr1), 32'd5);
        checkOutput("dut1 err_count", 32'(er1), 32'd2);

        // Out-of-range writes below and above the window must not alias into memory.
        applyStimulus(1, mk(1'b1, Base - 32'h4,   4'hF, 32'h5555_5555, 4'd1, 1'b1, 32'hDEAD_BEEF), 1'b1);
        applyStimulus(1, mk(1'b1, Base + 32'h400, 4'hF, 32'h6666_6666, 4'd2, 1'b1, 32'hDEAD_BEEF), 1'b1);
        applyStimulus(1, mk(1'b0, Base + 32'h0,   4'hF, 32'h0,         4'd3, 1'b0, 32'h0), 1'b1);
        applyStimulus(1, mk(1'b0, Base + 32'h3FC, 4'hF, 32'h0,         4'd4, 1'b0, 32'h0), 1'b1);
        idle();
        waitDrain();
        checkOutput("dut1 err_count after oor writes", 32'(er1), 32'd4);
        checkOutput("dut1 wr_count after oor writes", 32'(wr1), 32'd5);

        // Latency 3: back-to-back writes then reads must come back in order with no gaps.
        testmode = 1'b1;
        for (int i = 0; i < 4; i++)
            applyStimulus(3, mk(1'b1, Base + 32'(4 * i), 4'hF, 32'h100 + 32'(i), 4'(4 + i), 1'b0, 32'h0), 1'b1);
        for (int i = 0; i < 4; i++)
            applyStimulus(3, mk(1'b0, Base + 32'(4 * i), 4'hF, 32'h0, 4'(i), 1'b0, 32'h100 + 32'(i)), 1'b1);
        idle();
        waitDrain();
        testmode = 1'b0;
        checkOutput("dut3 wr_count", 32'(wr3), 32'd4);
        checkOutput("dut3 rd_count", 32'(rd3), 32'd4);

        // Reset with two reads still in the delay line; none may surface afterwards.
        applyStimulus(3, mk(1'b0, Base + 32'h0, 4'hF, 32'h0, 4'd1, 1'b0, 32'h0), 1'b0);
        applyStimulus(3, mk(1'b0, Base + 32'h4, 4'hF, 32'h0, 4'd2, 1'b0, 32'h0), 1'b0);
        idle();
        rstN3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("dut3 rvalid in reset", 32'(rsp3.rvalid), 32'd0);
        checkOutput("dut3 counters in reset", {rd3 | wr3, er3}, 32'd0);
        rstN3 = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        applyStimulus(3, mk(1'b0, Base + 32'h0, 4'hF, 32'h0, 4'd5, 1'b0, 32'h0), 1'b1);
        applyStimulus(3, mk(1'b0, Base + 32'hC, 4'hF, 32'h0, 4'd6, 1'b0, 32'h0), 1'b1);
        idle();
        waitDrain();
        checkOutput("dut3 rd_count after reset", 32'(rd3), 32'd2);
        checkOutput("dut3 wr_count after reset", 32'(wr3), 32'd0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
